csc_422_subsampler: RTL
=======================

# csc_422_subsampler

Parametrised YUV444-to-YUV422 chroma subsampler that follows the colour-space converter in the frame-buffer write path. It takes C_PORT_NUM pixels per clock and emits the packed 4:2:2 stream. Even pixels carry U and odd pixels carry V. The chroma mode is runtime-selectable: cosited drop or 2-tap average. The active port count (1/2/4) is runtime-selectable, and chroma pairs that straddle clock beats are supported. VS/HS/DE are delay-matched to the data.

## Interface
Parameters:
- C_PORT_NUM, 2, physical pixels per clock; legal values 1, 2, 4.
- C_BPC, 8, bits per component.

Ports:
- CLK_I  in  1  single clock.
- RST_I  in  1  synchronous, active-high reset.
- MODE_I  in  1  chroma mode: 0 = drop (cosited, use even pixel's chroma), 1 = average.
- ACTUAL_PORT_NUM_I  in  3  active ports: 1, 2 or 4, and ≤ C_PORT_NUM.
- VS_I, HS_I, DE_I  in  1 each  input sync/enable.
- Y_I, U_I, V_I  in  C_PORT_NUM*C_BPC each  components; lane 0 (LSBs) is the earliest pixel.
- VS_O, HS_O, DE_O  out  1 each  syncs delayed 2 cycles.
- DATA_O  out  C_PORT_NUM*2*C_BPC  per lane {C,Y}, lane 0 in LSBs; C = U on even pixel index, V on odd.

## Operation
- Pixel index k:
  - k counts from 0 at the first DE_I-high beat of each line.
  - k advances by ACTUAL_PORT_NUM_I per DE beat.
  - k resets whenever DE_I is low.
- Line config register:
  - MODE_I and ACTUAL_PORT_NUM_I are captured on the DE_I rising edge.
  - The captured values hold for the whole line; changes mid-line are ignored.
- Pairing: chroma for pair (k even, k+1).
  - Drop mode: C_k = U_k, C_{k+1} = V_k.
  - Average mode: C_k = (U_k + U_{k+1} + 1) >> 1 and C_{k+1} = (V_k + V_{k+1} + 1) >> 1.
  - Average uses a C_BPC+1 bit sum and cannot overflow.
- ACTUAL_PORT_NUM_I = 2 or 4: pairs lie within a beat; no cross-beat state.
- ACTUAL_PORT_NUM_I = 1:
  - A pair spans two beats. An internal phase bit tracks it: 0 = even pixel held, 1 = odd.
  - The even pixel's U/V are buffered one beat.
- Odd line length (port = 1, DE_I falls while phase = 1 after an even pixel): the lone even pixel pairs with itself, so average = own U.
- Lanes ≥ ACTUAL_PORT_NUM_I output zero data.
- Y passes through unchanged, delay-matched.
- Reset:
  - Pipeline, phase and line config clear; line config resets to MODE 0, port count 1.
  - All outputs are 0 from the first clock edge with RST_I high.
  - The first line after reset starts at even phase.

## Timing
- Fixed latency of 2 cycles from input beat to DATA_O/DE_O, for all modes and port counts.
  - Stage 1: capture, and buffer the even pixel.
  - Stage 2: pair resolve and output register.
- VS_O/HS_O/DE_O equal VS_I/HS_I/DE_I delayed exactly 2 cycles.
- DE_O pattern matches DE_I exactly; there are no bubbles and no extra beats.
- Reset values: VS_O = HS_O = DE_O = 0, DATA_O = 0.
- RST_I asserted mid-line:
  - Outputs are 0 at the next edge.
  - In-flight pixels are discarded; there is no partial output after release.
- DE_I gaps inside a line are not supported: any DE_I low ends the line and resets phase.
- Back-to-back lines with a single DE_I-low cycle are supported. The new line starts at even phase and takes its config from the new DE_I rising edge.
- Simultaneous DE_I rise and RST_I: reset wins. The line is ignored until the next DE_I rise after reset is released.

## Test plan
- Drop, port = 1, C_PORT_NUM = 2, 4-pixel line with Y = k, U = 0x10+k, V = 0x80+k → DATA_O lane 0 from cycle +2: 0x1000, 0x8001, 0x1202, 0x8203; lane 1 = 0; DE_O high for 4 cycles.
- Average, port = 1, pixel 0 (U = 0x10, V = 0x20), pixel 1 (U = 0x13, V = 0x21) → C0 = 0x12, C1 = 0x21; extremes U = 0xFF, 0xFF → 0xFF.
- Average, port = 2, single beat: lanes U = {0x13, 0x10}, V = {0x21, 0x20} → lane 0 C = 0x12, lane 1 C = 0x21 at latency 2.
- Odd line, port = 1, average, 3 pixels with pixel 2 U = 0x40 → pixel 2 output C = 0x40; the next line starts at even phase (U emitted first).
- MODE_I toggled 0→1 mid-line → the current line stays in drop mode; the next line averages.
- RST_I pulsed one cycle mid-line → all outputs 0 the following cycle; a new line after release produces correct even-phase output at latency 2.

Source files
------------

// File: rtl/csc_422_subsampler.sv
// YUV444 -> YUV422 chroma subsampler: drop or 2-tap average, runtime port count,
// fixed two-cycle latency with syncs delay-matched to the data.
module csc_422_subsampler #(
   parameter int C_PORT_NUM = 2,
   parameter int C_BPC      = 8
) (
   input  logic                              CLK_I,
   input  logic                              RST_I,
   input  logic                              MODE_I,
   input  logic [2:0]                        ACTUAL_PORT_NUM_I,
   input  logic                              VS_I,
   input  logic                              HS_I,
   input  logic                              DE_I,
   input  logic [C_PORT_NUM*C_BPC-1:0]       Y_I,
   input  logic [C_PORT_NUM*C_BPC-1:0]       U_I,
   input  logic [C_PORT_NUM*C_BPC-1:0]       V_I,
   output logic                              VS_O,
   output logic                              HS_O,
   output logic                              DE_O,
   output logic [C_PORT_NUM*2*C_BPC-1:0]     DATA_O
);

   localparam int W  = C_PORT_NUM * C_BPC;
   localparam int LW = 2 * C_BPC;

   // Valid/ready note: there is no backpressure; every active DE_I beat is
   // accepted and appears on DATA_O/DE_O exactly two cycles later.

   function automatic logic [C_BPC-1:0] avg2(input logic [C_BPC-1:0] a, input logic [C_BPC-1:0] b);
      logic [C_BPC:0] s;
      s = {1'b0, a} + {1'b0, b} + (C_BPC+1)'(1);
      return s[C_BPC:1];
   endfunction

   logic           blk;
   logic           act_prev;
   logic           phase;
   logic           cfg_mode;
   logic [2:0]     cfg_port;
   logic           active;
   logic           rise;
   logic           mode_eff;
   logic [2:0]     port_eff;

   logic           s1_de, s1_vs, s1_hs, s1_mode, s1_phase;
   logic [2:0]     s1_port;
   logic [W-1:0]   s1_y, s1_u, s1_v;
   logic [C_BPC-1:0] vbuf;
   logic [C_PORT_NUM*LW-1:0] data_nxt;

   // A line that was already high when reset released is blocked until DE_I drops.
   assign active   = DE_I & ~blk;
   assign rise     = active & ~act_prev;
   assign mode_eff = rise ? MODE_I : cfg_mode;
   assign port_eff = rise ? ACTUAL_PORT_NUM_I : cfg_port;

   for (genvar j = 0; j < C_PORT_NUM; j++) begin : g_lane
      localparam int JN = (j + 1 < C_PORT_NUM) ? j + 1 : j;
      localparam int JP = (j > 0) ? j - 1 : 0;
      logic [C_BPC-1:0] c;
      logic [C_BPC-1:0] partner;

      always_comb begin
         c       = '0;
         partner = active ? U_I[C_BPC-1:0] : s1_u[C_BPC-1:0];
         if (s1_port == 3'd1) begin
            // Single-port pairs span beats; a lone even pixel at line end pairs with itself.
            if (j == 0) begin
               if (!s1_phase)
                  c = s1_mode ? avg2(s1_u[C_BPC-1:0], partner) : s1_u[C_BPC-1:0];
               else
                  c = s1_mode ? avg2(vbuf, s1_v[C_BPC-1:0]) : vbuf;
            end
         end else if (j % 2 == 0) begin
            c = s1_mode ? avg2(s1_u[j*C_BPC +: C_BPC], s1_u[JN*C_BPC +: C_BPC])
                        : s1_u[j*C_BPC +: C_BPC];
         end else begin
            c = s1_mode ? avg2(s1_v[JP*C_BPC +: C_BPC], s1_v[j*C_BPC +: C_BPC])
                        : s1_v[JP*C_BPC +: C_BPC];
         end
      end

      assign data_nxt[j*LW +: LW] = (s1_de && (s1_port > 3'(j)))
                                    ? {c, s1_y[j*C_BPC +: C_BPC]} : '0;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         blk      <= DE_I;
         act_prev <= 1'b0;
         phase    <= 1'b0;
         cfg_mode <= 1'b0;
         cfg_port <= 3'd1;
         s1_de    <= 1'b0;
         s1_vs    <= 1'b0;
         s1_hs    <= 1'b0;
         s1_mode  <= 1'b0;
         s1_phase <= 1'b0;
         s1_port  <= 3'd1;
         s1_y     <= '0;
         s1_u     <= '0;
         s1_v     <= '0;
         vbuf     <= '0;
         VS_O     <= 1'b0;
         HS_O     <= 1'b0;
         DE_O     <= 1'b0;
         DATA_O   <= '0;
      end else begin
         blk      <= blk & DE_I;
         act_prev <= active;
         if (rise) begin
            cfg_mode <= MODE_I;
            cfg_port <= ACTUAL_PORT_NUM_I;
         end
         phase    <= (active && port_eff == 3'd1) ? ~phase : 1'b0;
         s1_de    <= active;
         s1_vs    <= VS_I;
         s1_hs    <= HS_I;
         s1_mode  <= mode_eff;
         s1_port  <= port_eff;
         s1_phase <= phase;
         s1_y     <= Y_I;
         s1_u     <= U_I;
         s1_v     <= V_I;
         if (s1_de && !s1_phase)
            vbuf <= s1_v[C_BPC-1:0];
         VS_O     <= s1_vs;
         HS_O     <= s1_hs;
         DE_O     <= s1_de;
         DATA_O   <= data_nxt;
      end
   end

endmodule
